// File: rtl/tone_pkg.sv
// tone_pkg: shared definitions for the tone generator / tone meter pair.
//   DEFAULT_HALFLEN_W : default width of the halflen encoding
//   DEFAULT_TIMEOUT   : default no-edge timeout in clock cycles (0.5 s at 50 MHz)
//   NO_TONE           : halflen value meaning "no tone"
//   state_t           : tone meter measurement state
package tone_pkg;

  localparam int unsigned DEFAULT_HALFLEN_W = 32;
  localparam int unsigned DEFAULT_TIMEOUT   = 25_000_000;
  localparam int unsigned NO_TONE           = 0;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: brings an asynchronous input into the clk domain and flags edges.
//   clk, rst_n : clock, asynchronous active-low reset
//   sig_in     : asynchronous input
//   level      : synchronised level (edge-register contents)
//   edge_stb   : registered one-cycle pulse on every rising or falling edge
// SYNC_STAGES must be at least 2.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic edge_stb
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_reg_q, edge_reg_d;
  logic                   edge_stb_q, edge_stb_d;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
    edge_reg_d = sync_q[SYNC_STAGES-1];
    edge_stb_d = sync_q[SYNC_STAGES-1] ^ edge_reg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      edge_reg_q <= 1'b0;
      edge_stb_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      edge_reg_q <= edge_reg_d;
      edge_stb_q <= edge_stb_d;
    end
  end

  assign level    = edge_reg_q;
  assign edge_stb = edge_stb_q;

endmodule

// File: rtl/tone_meter.sv
// tone_meter: measures the half-period of a square wave on sig_in and reports
// it in the tone generator's halflen encoding (half-period = halflen + 1 cycles).
//   clk, rst_n : 50 MHz clock, asynchronous active-low reset
//   sig_in     : asynchronous square-wave input
//   halflen    : last published measurement, NO_TONE when no tone
//   locked     : high while a valid measurement is held
//   meas_stb   : one-cycle pulse whenever halflen is published
// Build option TONE_METER_AVG_EN: publish the mean of the last 4 measurements,
// locking only once 4 measurements have been taken since leaving IDLE.
module tone_meter
  import tone_pkg::*;
#(
  parameter int unsigned HALFLEN_W   = DEFAULT_HALFLEN_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  output logic [HALFLEN_W-1:0] halflen,
  output logic                 locked,
  output logic                 meas_stb
);

  localparam logic [HALFLEN_W-1:0] CNT_MAX  = HALFLEN_W'(TIMEOUT);
  localparam logic [HALFLEN_W-1:0] CNT_LAST = HALFLEN_W'(TIMEOUT - 1);

  logic                 sig_level_unused;  // meter only needs the edge pulse
  logic                 edge_stb;

  state_t               state_q, state_d;
  logic [HALFLEN_W-1:0] cnt_q, cnt_d;
  logic [HALFLEN_W-1:0] halflen_q, halflen_d;
  logic                 locked_q, locked_d;
  logic                 meas_stb_q, meas_stb_d;

  logic                 timeout;
  logic                 pub_ok;
  logic [HALFLEN_W-1:0] pub_val;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .level   (sig_level_unused),
    .edge_stb(edge_stb)
  );

  // An edge in the same cycle as the timeout takes priority.
  always_comb begin
    timeout = (state_q != IDLE) && !edge_stb && (cnt_q == CNT_LAST);
  end

`ifdef TONE_METER_AVG_EN
  logic [HALFLEN_W-1:0] hist_q [4];
  logic [HALFLEN_W-1:0] hist_d [4];
  logic [1:0]           hcnt_q, hcnt_d;
  logic [HALFLEN_W+1:0] sum;

  // Mean of the three newest stored entries plus the measurement in flight.
  always_comb begin
    hist_d  = hist_q;
    hcnt_d  = hcnt_q;
    sum     = {2'b00, cnt_q} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
            + {2'b00, hist_q[2]};
    pub_val = sum[HALFLEN_W+1:2];
    pub_ok  = (state_q == LOCKED) || (hcnt_q == 2'd3);
    if (state_q != IDLE) begin
      if (edge_stb) begin
        hist_d[0] = cnt_q;
        hist_d[1] = hist_q[0];
        hist_d[2] = hist_q[1];
        hist_d[3] = hist_q[2];
        if (hcnt_q != 2'd3) hcnt_d = hcnt_q + 2'd1;
      end else if (timeout) begin
        hist_d = '{default: '0};
        hcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) hist_q[i] <= '0;
      hcnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      hcnt_q <= hcnt_d;
    end
  end
`else
  always_comb begin
    pub_ok  = 1'b1;
    pub_val = cnt_q;
  end
`endif

  always_comb begin
    state_d    = state_q;
    halflen_d  = halflen_q;
    locked_d   = locked_q;
    meas_stb_d = 1'b0;

    if (edge_stb)              cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + HALFLEN_W'(1);

    case (state_q)
      IDLE: begin
        if (edge_stb) state_d = ARMED;
      end
      ARMED, LOCKED: begin
        if (edge_stb) begin
          if (pub_ok) begin
            state_d    = LOCKED;
            halflen_d  = pub_val;
            locked_d   = 1'b1;
            meas_stb_d = 1'b1;
          end
        end else if (timeout) begin
          state_d   = IDLE;
          halflen_d = HALFLEN_W'(NO_TONE);
          locked_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      halflen_q  <= '0;
      locked_q   <= 1'b0;
      meas_stb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halflen_q  <= halflen_d;
      locked_q   <= locked_d;
      meas_stb_q <= meas_stb_d;
    end
  end

  assign halflen  = halflen_q;
  assign locked   = locked_q;
  assign meas_stb = meas_stb_q;

endmodule

// File: tb/tb_tone_meter.sv
// tb_tone_meter: directed tests for tone_meter with TIMEOUT=100, SYNC_STAGES=2.
// Expected values follow from: sig_in changed after posedge T is seen as an
// edge pulse after posedge T+3 and published after posedge T+4; the
// measurement is the edge spacing minus one; timeout fires 104 cycles after
// the last sig_in change.
module tb_tone_meter;

  localparam int unsigned W = 32;

  logic         clk    = 1'b0;
  logic         clk_en = 1'b1;
  logic         rst_n  = 1'b1;
  logic         sig_in = 1'b0;
  logic [W-1:0] halflen;
  logic         locked;
  logic         meas_stb;

  int unsigned  errors   = 0;
  int unsigned  checks   = 0;
  int unsigned  cyc      = 0;
  int unsigned  last_tog = 0;

  int unsigned  stb_cyc[$];
  logic [W-1:0] stb_val[$];

  tone_meter #(
    .HALFLEN_W  (W),
    .SYNC_STAGES(2),
    .TIMEOUT    (100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .halflen (halflen),
    .locked  (locked),
    .meas_stb(meas_stb)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; sample 1 time unit after the edge and log publishes.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (meas_stb === 1'b1) begin
      stb_cyc.push_back(cyc);
      stb_val.push_back(halflen);
    end
  endtask

  // Toggle sig_in at cycles base+offs[i]; run until cyc reaches stop.
  task automatic wave(input int unsigned base, input int unsigned offs[$],
                      input int unsigned stop);
    while (cyc < stop) begin
      foreach (offs[i]) begin
        if (cyc == base + offs[i]) begin
          sig_in   = ~sig_in;
          last_tog = cyc;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (halflen !== '0)    begin errors++; $display("FAIL reset_halflen: got %0d expected 0", halflen); end
    checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    checks++; if (meas_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %0b expected 0", meas_stb); end
    tick(); tick();
    rst_n = 1'b1;
    stb_cyc.delete(); stb_val.delete();
    repeat (5) tick();
    checks++; if (locked !== 1'b0 || stb_cyc.size() != 0) begin
      errors++; $display("FAIL idle_quiet: locked=%0b stbs=%0d expected 0/0", locked, stb_cyc.size());
    end
  endtask

  task automatic test_loopback();
    int unsigned t0;
    int unsigned offs[$];
    stb_cyc.delete(); stb_val.delete();
    t0   = cyc;
    offs = '{0, 5, 10, 15, 20, 25, 30, 35};
    wave(t0, offs, t0 + 41);
    checks++; if (stb_cyc.size() != 7) begin errors++; $display("FAIL loopback_count: got %0d expected 7", stb_cyc.size()); end
    for (int k = 0; k < 7 && k < stb_cyc.size(); k++) begin
      checks++; if (stb_cyc[k] != t0 + 9 + 5 * k) begin
        errors++; $display("FAIL loopback_time[%0d]: got %0d expected %0d", k, stb_cyc[k] - t0, 9 + 5 * k);
      end
      checks++; if (stb_val[k] !== 32'd4) begin
        errors++; $display("FAIL loopback_val[%0d]: got %0d expected 4", k, stb_val[k]);
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loopback_locked: got %0b expected 1", locked); end
  endtask

  task automatic test_freq_change();
    int unsigned base;
    int unsigned offs[$];
    int unsigned exp_c[4];
    int unsigned exp_v[4];
    stb_cyc.delete(); stb_val.delete();
    base  = last_tog;
    offs  = '{7, 17, 27, 37};
    exp_c = '{11, 21, 31, 41};
    exp_v = '{6, 9, 9, 9};
    wave(base, offs, base + 43);
    checks++; if (stb_cyc.size() != 4) begin errors++; $display("FAIL freq_count: got %0d expected 4", stb_cyc.size()); end
    for (int k = 0; k < 4 && k < stb_cyc.size(); k++) begin
      checks++; if (stb_cyc[k] != base + exp_c[k] || stb_val[k] !== W'(exp_v[k])) begin
        errors++; $display("FAIL freq_pub[%0d]: got @%0d=%0d expected @%0d=%0d", k, stb_cyc[k] - base, stb_val[k], exp_c[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int unsigned base;
    stb_cyc.delete(); stb_val.delete();
    base = last_tog;
    while (cyc < base + 110) begin
      tick();
      if (cyc == base + 103) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL timeout_early: locked got %0b expected 1", locked); end
      end
      if (cyc == base + 104) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_locked: got %0b expected 0", locked); end
        checks++; if (halflen !== '0)  begin errors++; $display("FAIL timeout_halflen: got %0d expected 0", halflen); end
      end
    end
    checks++; if (stb_cyc.size() != 0) begin errors++; $display("FAIL timeout_stb: got %0d pulses expected 0", stb_cyc.size()); end
  endtask

  task automatic test_asymmetric();
    int unsigned t0;
    int unsigned offs[$];
    stb_cyc.delete(); stb_val.delete();
    t0   = cyc + 2;
    offs = '{0, 3, 10, 13, 20};
    wave(t0, offs, t0 + 26);
`ifdef TONE_METER_AVG_EN
    checks++; if (stb_cyc.size() != 1) begin errors++; $display("FAIL asym_count: got %0d expected 1", stb_cyc.size()); end
    if (stb_cyc.size() > 0) begin
      checks++; if (stb_cyc[0] != t0 + 24 || stb_val[0] !== 32'd4) begin
        errors++; $display("FAIL asym_avg: got @%0d=%0d expected @24=4", stb_cyc[0] - t0, stb_val[0]);
      end
    end
`else
    begin
      int unsigned exp_c[4];
      int unsigned exp_v[4];
      exp_c = '{7, 14, 17, 24};
      exp_v = '{2, 6, 2, 6};
      checks++; if (stb_cyc.size() != 4) begin errors++; $display("FAIL asym_count: got %0d expected 4", stb_cyc.size()); end
      for (int k = 0; k < 4 && k < stb_cyc.size(); k++) begin
        checks++; if (stb_cyc[k] != t0 + exp_c[k] || stb_val[k] !== W'(exp_v[k])) begin
          errors++; $display("FAIL asym_pub[%0d]: got @%0d=%0d expected @%0d=%0d", k, stb_cyc[k] - t0, stb_val[k], exp_c[k], exp_v[k]);
        end
      end
    end
`endif
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL asym_locked: got %0b expected 1", locked); end
  endtask

  task automatic test_async_reset();
    int unsigned t0;
    int unsigned offs[$];
    repeat (3) tick();
    @(negedge clk);
    clk_en = 1'b0;
    #3;
    sig_in = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++; if (halflen !== '0)    begin errors++; $display("FAIL areset_halflen: got %0d expected 0", halflen); end
    checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL areset_locked: got %0b expected 0", locked); end
    checks++; if (meas_stb !== 1'b0) begin errors++; $display("FAIL areset_stb: got %0b expected 0", meas_stb); end
    #10 rst_n = 1'b1;
    #2 clk_en = 1'b1;
    stb_cyc.delete(); stb_val.delete();
    t0   = cyc + 2;
    offs = '{0, 6};
    wave(t0, offs, t0 + 13);
    checks++; if (stb_cyc.size() != 1) begin errors++; $display("FAIL areset_arm_count: got %0d expected 1", stb_cyc.size()); end
    if (stb_cyc.size() > 0) begin
      checks++; if (stb_cyc[0] != t0 + 10 || stb_val[0] !== 32'd5) begin
        errors++; $display("FAIL areset_first: got @%0d=%0d expected @10=5", stb_cyc[0] - t0, stb_val[0]);
      end
    end
  endtask

  task automatic test_coincident();
    int unsigned t0;
    int unsigned offs[$];
    int unsigned exp_c[4];
    int unsigned exp_v[4];
    repeat (120) tick();
    stb_cyc.delete(); stb_val.delete();
    t0    = cyc + 1;
    offs  = '{0, 10, 20, 120, 221, 231};
    exp_c = '{14, 24, 124, 235};
    exp_v = '{9, 9, 99, 9};
    wave(t0, offs, t0 + 125);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL coincident_locked: got %0b expected 1", locked); end
    wave(t0, offs, t0 + 225);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL late_edge_locked: got %0b expected 0", locked); end
    wave(t0, offs, t0 + 237);
    checks++; if (stb_cyc.size() != 4) begin errors++; $display("FAIL coincident_count: got %0d expected 4", stb_cyc.size()); end
    for (int k = 0; k < 4 && k < stb_cyc.size(); k++) begin
      checks++; if (stb_cyc[k] != t0 + exp_c[k] || stb_val[k] !== W'(exp_v[k])) begin
        errors++; $display("FAIL coincident_pub[%0d]: got @%0d=%0d expected @%0d=%0d", k, stb_cyc[k] - t0, stb_val[k], exp_c[k], exp_v[k]);
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rearm_locked: got %0b expected 1", locked); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_freq_change();
    test_timeout();
    test_asymmetric();
    test_async_reset();
    test_coincident();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_meter.md
Name: tone_meter

Overview:
- Measures the half-period of an incoming square wave and reports it in the same `halflen` encoding the tone generator consumes.
- Encoding: half-period = `halflen` + 1 clock cycles. `halflen` = 0 means no tone.
- A tone generator driving `sig_in` in loopback reads back its own programmed value.
- Sits beside the tone generator on the peripheral bus, as a readable frequency/tone-detect register source.

Parameters:
- HALFLEN_W, 32, width of measurement and output.
- SYNC_STAGES, 2, number of synchroniser flops on `sig_in` (minimum 2).
- TIMEOUT, 25_000_000, cycles without an edge before the tone is declared lost (0.5 s at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- sig_in  in  1  asynchronous square-wave input.
- halflen  out  HALFLEN_W  last published measurement (cycles per half-period − 1); 0 = no tone.
- locked  out  1  high while a valid measurement is held.
- meas_stb  out  1  one-cycle pulse each time `halflen` is updated.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Assertion immediately clears `halflen`=0, `locked`=0, `meas_stb`=0, counter=0, synchroniser=0 and state=IDLE, independent of `clk`.
- Input path: `sig_in` → SYNC_STAGES flops → one edge-register. An edge is any difference between the last synchroniser stage and the edge-register. Both rising and falling edges count.
- Counter: cleared to 0 on an edge cycle; otherwise increments by 1 and saturates at TIMEOUT. For edge detections D cycles apart, the counter value at the second edge is D−1; that value is the measurement m.
- State IDLE: counter runs. The first edge → ARMED; no measurement is produced.
- State ARMED: on an edge, publish m → LOCKED.
- State LOCKED: on every edge, publish m.
- Publish: on the cycle after the edge, `halflen`<=m, `meas_stb`=1 for exactly one cycle, `locked`=1.
- Latency: `sig_in` transition → `halflen` update = SYNC_STAGES+2 cycles.
- Timeout: in ARMED or LOCKED, when the counter reaches TIMEOUT−1 with no edge that cycle → IDLE, `halflen`<=0, `locked`<=0. No `meas_stb` on timeout.
- Simultaneous edge and timeout in the same cycle: the edge wins, and the measurement is published.
- Asymmetric duty: each half is measured and published separately, so `halflen` alternates.
- Minimum measurable half-period is 1 cycle (m=0). This is indistinguishable in `halflen` from "no tone"; `locked` disambiguates.
- Output width: m never exceeds TIMEOUT−1; no wrap.

Optional Feature:
- Macro TONE_METER_AVG_EN.
- Defined:
  - A 4-entry history of measurements is kept.
  - The published value is the sum of the 4 entries (HALFLEN_W+2-bit) >> 2, truncated.
  - `locked` and the first `meas_stb` occur only after 4 measurements since leaving IDLE; thereafter one publish per edge.
  - History is cleared on reset and on entry to IDLE.
- Undefined: each measurement is published directly as above.

Decomposition:
- Package tone_pkg:
  - HALFLEN_W default.
  - DEFAULT_TIMEOUT.
  - State typedef (IDLE, ARMED, LOCKED).
  - Constant NO_TONE = 0, shared with the tone generator.
- Sub-module edge_sync: synchroniser plus edge-register. Outputs the synchronised level and a one-cycle edge pulse. Parameter: SYNC_STAGES.

Test Plan:
- Loopback: tone generator `halflen`=4 drives `sig_in` (toggle every 5 cycles) → first `meas_stb` at the second detected edge + 1 cycle, `halflen`=4, `locked`=1, then `meas_stb` every 5 cycles.
- Timeout: TIMEOUT=100, toggle every 10 cycles then hold `sig_in` → 100 cycles after the last edge, `locked`=0 and `halflen`=0, with no `meas_stb`.
- Frequency change: generator `halflen` 4→9 → at most one transitional value published, then stable `halflen`=9.
- Async reset: pull `rst_n` low mid-count with `clk` stopped → `halflen`=0, `locked`=0 immediately. On release, the first edge only arms.
- Asymmetric input, high 3 / low 7 cycles → `halflen` alternates 2, 6. With TONE_METER_AVG_EN → `halflen`=4 after the 4th measurement, `locked` rising at that point.
- Edge coincident with the timeout cycle (TIMEOUT=100, edge exactly 100 cycles after the previous one) → `halflen`=99, `locked` stays 1.
